// File: rtl/irq_capture_arb.sv
// irq_capture_arb: synchronises raw IRQ lines and captures edges or follows levels per source.
// It masks the pending sources and offers the lowest-index one as a registered request.
// An ack/EOI handshake holds the offered cause stable until firmware retires it.
//   clk, rst        clock, synchronous active-high reset
//   irq_in          raw asynchronous lines (bit 0 DIO1 -> cause 16, bit 1 timer -> cause 17)
//   irq_edge_mode   per source: 1 rising-edge captured, 0 level-following
//   irq_enable      per-source mask
//   clr_valid/idx   one-cycle clear of an edge-captured pending bit
//   irq_ack/eoi     trap taken / ISR complete pulses
//   pending         pending vector
//   irq_req/cause   registered request and cause to the CPU
//   in_service      high between ack and EOI
module irq_capture_arb #(
    parameter int NUM_IRQ = 4,
    parameter int BASE_CAUSE = 16,
    parameter int SYNC_STAGES = 2,
    localparam int IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic [NUM_IRQ-1:0] irq_edge_mode,
    input  logic [NUM_IRQ-1:0] irq_enable,
    input  logic               clr_valid,
    input  logic [IW-1:0]      clr_idx,
    input  logic               irq_ack,
    input  logic               irq_eoi,
    output logic [NUM_IRQ-1:0] pending,
    output logic               irq_req,
    output logic [4:0]         irq_cause,
    output logic               in_service
);
    typedef enum logic {IDLE, SERVICE} state_t;
    state_t state, state_n;
    logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
    logic [SYNC_STAGES-1:0] fill;
    logic [NUM_IRQ-1:0] sync, prev, armed, rise, edge_q, clr_hit, eligible;
    logic [4:0] win_cause;
    logic take;

    assign sync = sync_q[SYNC_STAGES-1];
    // a line only produces edges after it has been seen low in a real post-reset sample,
    // so a line already high at reset release is not mistaken for a fresh edge
    assign rise = sync & ~prev & armed;
    assign pending = (irq_edge_mode & edge_q) | (~irq_edge_mode & sync);
    assign eligible = pending & irq_enable;
    assign in_service = state == SERVICE;
    assign take = ~in_service & irq_ack & irq_req;

    always_comb begin
        clr_hit = '0;
        win_cause = 5'(BASE_CAUSE);
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (clr_valid && int'(clr_idx) == i) clr_hit[i] = 1'b1;
            if (eligible[i]) win_cause = 5'(BASE_CAUSE + i);
        end
    end

    always_comb state_n = in_service ? (irq_eoi ? IDLE : SERVICE) : (take ? SERVICE : IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
            fill <= '0;
            prev <= '0;
            armed <= '0;
            edge_q <= '0;
            state <= IDLE;
            irq_req <= 1'b0;
            irq_cause <= '0;
        end else begin
            sync_q[0] <= irq_in;
            for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
            // fill marks when the chain output holds a real sample rather than reset zeros
            fill <= {fill[SYNC_STAGES-2:0], 1'b1};
            prev <= sync;
            armed <= armed | (~sync & {NUM_IRQ{fill[SYNC_STAGES-1]}});
            // set beats clear; leaving edge mode discards any captured edge
            edge_q <= irq_edge_mode & (rise | (edge_q & ~clr_hit));
            state <= state_n;
            // the accepting ack cycle suppresses the request and freezes the cause
            irq_req <= |eligible & ~in_service & ~take;
            if (|eligible && !in_service && !take) irq_cause <= win_cause;
        end
    end
endmodule

// File: doc/irq_capture_arb.md
Name: irq_capture_arb

Overview:
- Interrupt front end between external/peripheral IRQ lines (DIO1 on ui_in[0], timer compare) and the CPU interrupt entry.
- Synchronises raw lines, captures rising edges or follows levels per source, and applies enable masks.
- Presents the single highest-priority pending cause (lowest index wins, so IRQ16 beats IRQ17).
- An ack/EOI handshake holds the in-service cause stable until firmware retires it.

Parameters:
- NUM_IRQ, 4: number of sources, mapped to causes BASE_CAUSE..BASE_CAUSE+NUM_IRQ-1.
- BASE_CAUSE, 16: mcause value of source 0.
- SYNC_STAGES, 2: synchroniser depth on irq_in (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- irq_in  in  NUM_IRQ  raw asynchronous interrupt lines; bit 0 = DIO1 (IRQ16), bit 1 = timer (IRQ17).
- irq_edge_mode  in  NUM_IRQ  per source: 1 = rising-edge captured; 0 = level (pending follows the synchronised line).
- irq_enable  in  NUM_IRQ  per-source mask (mie equivalent).
- clr_valid  in  1  one-cycle pulse: clear the pending bit of source clr_idx (edge-mode sources only).
- clr_idx  in  clog2(NUM_IRQ)  source index to clear.
- irq_ack  in  1  one-cycle pulse: CPU has taken the trap on irq_cause.
- irq_eoi  in  1  one-cycle pulse: ISR complete (mret).
- pending  out  NUM_IRQ  pending vector (mip[BASE_CAUSE+:NUM_IRQ] view).
- irq_req  out  1  registered interrupt request to the CPU.
- irq_cause  out  5  registered cause of the current/offered interrupt.
- in_service  out  1  high between ack and EOI.

Behaviour:
- Reset values: sync chain 0, edge-history 0, pending 0, irq_req 0, irq_cause 0, in_service 0. A line already high at reset release produces no edge until it falls and rises again.
- Sync: SYNC_STAGES flops per line, giving sync[i]. Edge detect: rise[i] = sync[i] & ~prev[i], where prev is a registered copy of sync.
- Edge-mode pending register:
  - Set on rise[i].
  - Cleared by clr_valid when clr_idx==i.
  - Set and clear in the same cycle: set wins, so the bit stays 1.
  - Clearing an already-clear bit is a no-op.
  - clr_idx >= NUM_IRQ is ignored.
- Level-mode pending[i] = sync[i]. clr_valid has no effect on a level-mode source.
- Mode change while pending: the edge register is cleared whenever irq_edge_mode[i]=0.
- Latency (edge mode): irq_in rises before clk edge E0. sync valid at E0+SYNC_STAGES-1, pending at E0+SYNC_STAGES, irq_req/irq_cause at E0+SYNC_STAGES+1. With default SYNC_STAGES=2, pending goes high 2 clocks and irq_req 3 clocks after the first sampling edge.
- Arbitration, computed combinationally each cycle:
  - eligible = pending & irq_enable.
  - win = lowest set index of eligible.
  - Registered: irq_req <= |eligible & ~in_service.
  - irq_cause <= BASE_CAUSE + win when |eligible & ~in_service; otherwise irq_cause holds its value.
- State machine (2 states):
  - IDLE: in_service=0. On irq_ack with irq_req=1, go to SERVICE, latch the cause (irq_cause frozen), and force irq_req to 0 on the next cycle.
  - irq_ack while irq_req=0 is ignored.
  - SERVICE: in_service=1. irq_req is held 0 (no nesting). pending keeps capturing new edges.
  - On irq_eoi, go to IDLE. Arbitration resumes on the next cycle, so a still-pending lower-priority source raises irq_req 1 cycle after EOI.
  - irq_eoi in IDLE is ignored.
  - irq_ack and irq_eoi in the same cycle: EOI takes effect only in SERVICE, ack only in IDLE. No conflict is possible.
- Firmware clearing the in-service source does not end SERVICE; only irq_eoi does.
- Disabling the winning source while irq_req=1 (IDLE): irq_req drops the next cycle, or irq_cause moves to the next eligible source.
- Synchronous rst mid-SERVICE: returns to IDLE with all state cleared on that edge.

Test Plan:
- Timer alone: edge_mode=2'b11, enable=2'b11, pulse irq_in[1] -> pending=4'b0010 at E0+2; irq_req=1 and irq_cause=17 at E0+3; ack -> in_service=1, irq_req=0; clr_idx=1, eoi -> pending=0, irq_req stays 0.
- DIO1 alone: rise irq_in[0] -> irq_cause=16. Hold irq_in[0] high for 20 cycles after clearing -> no re-pend. Fall then rise -> pends again.
- Simultaneous: irq_in[0] and irq_in[1] rise on the same cycle -> irq_cause=16. Ack, clear 0, EOI -> irq_req=1, irq_cause=17 exactly 1 cycle after EOI. Ack, clear 1, EOI -> irq_req=0.
- Set/clear collision: clr_valid, clr_idx=0 on the same cycle rise[0] fires -> pending[0]=1 afterwards. clr_idx=7 -> no change.
- Masking and level mode: source 2 in level mode with enable[2]=0 -> pending[2] tracks the line and irq_req=0. Enable it -> irq_req=1, cause=18. clr_valid idx 2 -> pending[2] stays 1.
- Reset mid-service: in SERVICE with pending=4'b0011, assert rst for 1 cycle -> pending=0, in_service=0, irq_req=0, irq_cause=0 on the next cycle.
